// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station dispatch allocator.
// Holds station encodings, default sizing constants and index-width helpers.
package rs_pkg;

  // Station select encoding carried by RSstation (2'b10 is unused and needs no entry)
  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_BR   = 2'b01,
    RS_NONE = 2'b11
  } rs_station_e;

  localparam int unsigned DEF_ALU_ENTRIES = 4;
  localparam int unsigned DEF_BR_ENTRIES  = 4;
  localparam int unsigned DEF_ROB_DEPTH   = 16;

  // Index width that never collapses to zero bits for single-entry structures
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_ALU_IDX_W = idx_w(DEF_ALU_ENTRIES);
  localparam int unsigned DEF_BR_IDX_W  = idx_w(DEF_BR_ENTRIES);
  localparam int unsigned DEF_ROB_TAG_W = idx_w(DEF_ROB_DEPTH);
  localparam int unsigned DEF_ROB_CNT_W = $clog2(DEF_ROB_DEPTH) + 1;

endpackage

// File: rtl/rs_dispatch_allocator_if.sv
// Dispatch bus between the decode stage and the RS/ROB allocator.
// master: decode / issue / commit side (drives requests, releases, commit, flush)
// slave : allocator (returns grant, stall, allocated indices and ROB status)
interface rs_dispatch_allocator_if
  import rs_pkg::*;
#(
  parameter int unsigned ALU_ENTRIES = DEF_ALU_ENTRIES,
  parameter int unsigned BR_ENTRIES  = DEF_BR_ENTRIES,
  parameter int unsigned ROB_DEPTH   = DEF_ROB_DEPTH
);

  localparam int unsigned ALU_IDX_W = idx_w(ALU_ENTRIES);
  localparam int unsigned BR_IDX_W  = idx_w(BR_ENTRIES);
  localparam int unsigned ROB_TAG_W = idx_w(ROB_DEPTH);

  // Request side
  logic                 instValid;
  logic                 stationRequest;
  logic [1:0]           RSstation;
  logic                 robWrite;
  logic                 aluRelease;
  logic [ALU_IDX_W-1:0] aluReleaseIdx;
  logic                 brRelease;
  logic [BR_IDX_W-1:0]  brReleaseIdx;
  logic                 robCommit;
  logic                 flush;

  // Response side
  logic                 dispatchGrant;
  logic                 stall;
  logic [ALU_IDX_W-1:0] aluSlot;
  logic [BR_IDX_W-1:0]  brSlot;
  logic [ROB_TAG_W-1:0] robTag;
  logic                 robFull;
  logic                 robEmpty;

  modport master (
    output instValid, stationRequest, RSstation, robWrite,
           aluRelease, aluReleaseIdx, brRelease, brReleaseIdx,
           robCommit, flush,
    input  dispatchGrant, stall, aluSlot, brSlot, robTag, robFull, robEmpty
  );

  modport slave (
    input  instValid, stationRequest, RSstation, robWrite,
           aluRelease, aluReleaseIdx, brRelease, brReleaseIdx,
           robCommit, flush,
    output dispatchGrant, stall, aluSlot, brSlot, robTag, robFull, robEmpty
  );

endinterface

// File: rtl/lowest_free_finder.sv
// Priority encoder returning the lowest-index clear bit of a busy bitmap.
// Ports: busy (N-bit occupancy), free_c (some bit clear), idx_c (lowest clear index, 0 if none)
module lowest_free_finder
  import rs_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        busy,
  output logic                free_c,
  output logic [idx_w(N)-1:0] idx_c
);

  localparam int unsigned IDX_W = idx_w(N);

  // Scan from the top down so the lowest clear bit is the last one written
  always_comb begin
    free_c = 1'b0;
    idx_c  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_c = 1'b1;
        idx_c  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_dispatch_allocator.sv
// Dispatch-side allocator for ALU/branch reservation stations and the ROB.
// Grants a decoded instruction in the same cycle when every resource it needs
// is free, otherwise stalls the front end; occupancy updates on the next edge.
// Ports: clk, reset (sync, active high), bus (slave side of the dispatch bus).
module rs_dispatch_allocator
  import rs_pkg::*;
#(
  parameter int unsigned ALU_ENTRIES = DEF_ALU_ENTRIES,
  parameter int unsigned BR_ENTRIES  = DEF_BR_ENTRIES,
  parameter int unsigned ROB_DEPTH   = DEF_ROB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  rs_dispatch_allocator_if.slave bus
);

  localparam int unsigned ALU_IDX_W = idx_w(ALU_ENTRIES);
  localparam int unsigned BR_IDX_W  = idx_w(BR_ENTRIES);
  localparam int unsigned ROB_TAG_W = idx_w(ROB_DEPTH);
  localparam int unsigned ROB_CNT_W = $clog2(ROB_DEPTH) + 1;

  logic [ALU_ENTRIES-1:0] alu_busy_q, alu_busy_d;
  logic [BR_ENTRIES-1:0]  br_busy_q,  br_busy_d;
  logic [ROB_TAG_W-1:0]   rob_head_q, rob_head_d;
  logic [ROB_TAG_W-1:0]   rob_tail_q, rob_tail_d;
  logic [ROB_CNT_W-1:0]   rob_cnt_q,  rob_cnt_d;

  logic                 alu_free_c, br_free_c;
  logic [ALU_IDX_W-1:0] alu_idx_c;
  logic [BR_IDX_W-1:0]  br_idx_c;

  logic need_alu_c, need_br_c, need_rob_c;
  logic rob_full_c, rob_empty_c;
  logic grant_c, alloc_rob_c, retire_c;

  // Free-slot search works on pre-release state: a release is visible next cycle
  lowest_free_finder #(.N(ALU_ENTRIES)) u_alu_finder (
    .busy   (alu_busy_q),
    .free_c (alu_free_c),
    .idx_c  (alu_idx_c)
  );

  lowest_free_finder #(.N(BR_ENTRIES)) u_br_finder (
    .busy   (br_busy_q),
    .free_c (br_free_c),
    .idx_c  (br_idx_c)
  );

  // Resource need and grant decision
  always_comb begin
    need_alu_c  = bus.stationRequest && (bus.RSstation == RS_ALU);
    need_br_c   = bus.stationRequest && (bus.RSstation == RS_BR);
    need_rob_c  = bus.robWrite;
    rob_full_c  = (rob_cnt_q == ROB_CNT_W'(ROB_DEPTH));
    rob_empty_c = (rob_cnt_q == '0);
    // Reset is treated like flush so no grant escapes while state is being cleared
    grant_c     = bus.instValid && !bus.flush && !reset
                  && (!need_alu_c || alu_free_c)
                  && (!need_br_c  || br_free_c)
                  && (!need_rob_c || !rob_full_c);
    alloc_rob_c = grant_c && need_rob_c;
    retire_c    = bus.robCommit && !rob_empty_c;
  end

  assign bus.dispatchGrant = grant_c;
  assign bus.stall         = bus.instValid && !bus.flush && !reset && !grant_c;
  assign bus.aluSlot       = need_alu_c ? alu_idx_c : '0;
  assign bus.brSlot        = need_br_c  ? br_idx_c  : '0;
  assign bus.robTag        = rob_tail_q;
  assign bus.robFull       = rob_full_c;
  assign bus.robEmpty      = rob_empty_c;

  // Next-state: flush wipes everything and discards same-cycle release/commit
  always_comb begin
    alu_busy_d = alu_busy_q;
    br_busy_d  = br_busy_q;
    rob_head_d = rob_head_q;
    rob_tail_d = rob_tail_q;
    rob_cnt_d  = rob_cnt_q;

    if (bus.flush) begin
      alu_busy_d = '0;
      br_busy_d  = '0;
      rob_head_d = '0;
      rob_tail_d = '0;
      rob_cnt_d  = '0;
    end else begin
      // Release first so a different-entry allocation in the same cycle still lands
      if (bus.aluRelease) alu_busy_d[bus.aluReleaseIdx] = 1'b0;
      if (bus.brRelease)  br_busy_d[bus.brReleaseIdx]   = 1'b0;
      if (grant_c && need_alu_c) alu_busy_d[alu_idx_c] = 1'b1;
      if (grant_c && need_br_c)  br_busy_d[br_idx_c]   = 1'b1;

      // Power-of-two depth: pointers wrap by natural overflow
      if (alloc_rob_c) rob_tail_d = rob_tail_q + ROB_TAG_W'(1);
      if (retire_c)    rob_head_d = rob_head_q + ROB_TAG_W'(1);

      case ({alloc_rob_c, retire_c})
        2'b10:   rob_cnt_d = rob_cnt_q + ROB_CNT_W'(1);
        2'b01:   rob_cnt_d = rob_cnt_q - ROB_CNT_W'(1);
        default: rob_cnt_d = rob_cnt_q;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_busy_q <= '0;
      br_busy_q  <= '0;
      rob_head_q <= '0;
      rob_tail_q <= '0;
      rob_cnt_q  <= '0;
    end else begin
      alu_busy_q <= alu_busy_d;
      br_busy_q  <= br_busy_d;
      rob_head_q <= rob_head_d;
      rob_tail_q <= rob_tail_d;
      rob_cnt_q  <= rob_cnt_d;
    end
  end

  // Protocol checks: releasing a free entry or committing an empty ROB is an upstream bug
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush) begin
      assert (!(bus.aluRelease && !alu_busy_q[bus.aluReleaseIdx]));
      assert (!(bus.brRelease  && !br_busy_q[bus.brReleaseIdx]));
      assert (!(bus.robCommit  && rob_empty_c));
    end
  end

endmodule

// File: tb/tb_rs_dispatch_allocator.sv
module tb_rs_dispatch_allocator;
  import rs_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rs_dispatch_allocator_if #(
    .ALU_ENTRIES(4), .BR_ENTRIES(4), .ROB_DEPTH(16)
  ) bus ();

  rs_dispatch_allocator #(
    .ALU_ENTRIES(4), .BR_ENTRIES(4), .ROB_DEPTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic sr, input logic [1:0] st, input logic rw,
                        input logic ar, input logic [1:0] ai,
                        input logic br, input logic [1:0] bi,
                        input logic cm, input logic fl);
    bus.instValid      = iv;
    bus.stationRequest = sr;
    bus.RSstation      = st;
    bus.robWrite       = rw;
    bus.aluRelease     = ar;
    bus.aluReleaseIdx  = ai;
    bus.brRelease      = br;
    bus.brReleaseIdx   = bi;
    bus.robCommit      = cm;
    bus.flush          = fl;
  endtask

  // Settle, compare every output, then advance one clock
  task automatic cyc(input string tag, input logic g, input logic s,
                     input logic [1:0] a, input logic [1:0] b, input logic [3:0] t,
                     input logic f, input logic e);
    #1;
    chk({tag, ".grant"}, 32'(bus.dispatchGrant), 32'(g));
    chk({tag, ".stall"}, 32'(bus.stall),         32'(s));
    chk({tag, ".alu"},   32'(bus.aluSlot),       32'(a));
    chk({tag, ".br"},    32'(bus.brSlot),        32'(b));
    chk({tag, ".tag"},   32'(bus.robTag),        32'(t));
    chk({tag, ".full"},  32'(bus.robFull),       32'(f));
    chk({tag, ".empty"}, 32'(bus.robEmpty),      32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    set_in(0, 0, 2'b00, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    cyc("reset_idle", 0, 0, 2'd0, 2'd0, 4'd0, 0, 1);

    // Four R-type fill the ALU station, fifth stalls
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("rtype%0d", k), 1, 0, 2'(k), 2'd0, 4'(k), 0, (k == 0));
    cyc("rtype_full", 0, 1, 2'd0, 2'd0, 4'd4, 0, 0);

    // Release in N does not bypass: stall in N, grant slot 2 in N+1
    set_in(1, 1, RS_ALU, 1, 1, 2'd2, 0, 2'd0, 0, 0);
    cyc("rel_same_cyc", 0, 1, 2'd0, 2'd0, 4'd4, 0, 0);
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("rel_next_cyc", 1, 0, 2'd2, 2'd0, 4'd4, 0, 0);

    // JAL: ROB only; following branch still gets entry 0
    set_in(1, 0, RS_BR, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("jal", 1, 0, 2'd0, 2'd0, 4'd5, 0, 0);
    set_in(1, 1, RS_BR, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("br_after_jal", 1, 0, 2'd0, 2'd0, 4'd6, 0, 0);
    set_in(1, 0, RS_NONE, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("invalid_op", 1, 0, 2'd0, 2'd0, 4'd6, 0, 0);

    // Free ALU entries 0 and 1, then ping-pong allocate/release to fill the ROB
    set_in(0, 0, RS_ALU, 0, 1, 2'd0, 0, 2'd0, 0, 0);
    cyc("free0", 0, 0, 2'd0, 2'd0, 4'd6, 0, 0);
    set_in(0, 0, RS_ALU, 0, 1, 2'd1, 0, 2'd0, 0, 0);
    cyc("free1", 0, 0, 2'd0, 2'd0, 4'd6, 0, 0);
    for (int j = 0; j < 10; j++) begin
      set_in(1, 1, RS_ALU, 1, (j > 0), 2'((j + 1) % 2), 0, 2'd0, 0, 0);
      cyc($sformatf("itype%0d", j), 1, 0, 2'(j % 2), 2'd0, 4'(6 + j), 0, 0);
    end
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("rob_full_stall", 0, 1, 2'd0, 2'd0, 4'd0, 1, 0);
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 1, 0);
    cyc("commit_when_full", 0, 1, 2'd0, 2'd0, 4'd0, 1, 0);
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("wrap_grant", 1, 0, 2'd0, 2'd0, 4'd0, 0, 0);

    // Make room: four commits, two ALU releases
    set_in(0, 0, RS_ALU, 0, 1, 2'd2, 0, 2'd0, 1, 0);
    cyc("cm_rel2", 0, 0, 2'd0, 2'd0, 4'd1, 1, 0);
    set_in(0, 0, RS_ALU, 0, 1, 2'd3, 0, 2'd0, 1, 0);
    cyc("cm_rel3", 0, 0, 2'd0, 2'd0, 4'd1, 0, 0);
    set_in(0, 0, RS_ALU, 0, 0, 2'd0, 0, 2'd0, 1, 0);
    cyc("cm3", 0, 0, 2'd0, 2'd0, 4'd1, 0, 0);
    cyc("cm4", 0, 0, 2'd0, 2'd0, 4'd1, 0, 0);

    // Interleaved ALU / branch allocations
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("mix_alu0", 1, 0, 2'd2, 2'd0, 4'd1, 0, 0);
    set_in(1, 1, RS_BR, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("mix_br0", 1, 0, 2'd0, 2'd1, 4'd2, 0, 0);
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("mix_alu1", 1, 0, 2'd3, 2'd0, 4'd3, 0, 0);
    set_in(1, 1, RS_BR, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("mix_br1", 1, 0, 2'd0, 2'd2, 4'd4, 0, 0);

    // Flush with a request pending: no grant, no stall, state wiped next cycle
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 1, 1);
    cyc("flush", 0, 0, 2'd0, 2'd0, 4'd5, 1, 0);
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("post_flush_alu", 1, 0, 2'd0, 2'd0, 4'd0, 0, 1);
    set_in(1, 1, RS_BR, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("post_flush_br", 1, 0, 2'd0, 2'd0, 4'd1, 0, 0);

    // Reset mid-stream with busy entries
    set_in(0, 0, RS_ALU, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post_reset_idle", 0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
    set_in(1, 1, RS_ALU, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("post_reset_alu", 1, 0, 2'd0, 2'd0, 4'd0, 0, 1);
    set_in(1, 1, RS_BR, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    cyc("post_reset_br", 1, 0, 2'd0, 2'd0, 4'd1, 0, 0);
    set_in(0, 0, RS_ALU, 0, 0, 2'd0, 0, 2'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
